mem_port_arbiter: RTL and testbench

Sequences the byte-addressed RAM (Enable/ReadWrite/DataType/MOC handshake) and shares it between two requesters: instruction fetch (IF, word reads only) and data memory (DM, byte/half/word/doubleword, read or write). Converts each granted request into one or two RAM accesses and waits for MOC on each. Splits doublewords into two word beats, enforces a MOC timeout, and returns read data with a one-cycle Ack. Sits between the CPU control unit and the RAM model.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester RAM port sequencer: IF word fetches and DM byte..doubleword accesses.
// Doublewords are split into two word beats; each beat waits for MOC or times out.
module mem_port_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        IfReq,
    input  logic [31:0] IfAddr,
    output logic        IfAck,
    output logic [31:0] IfRData,
    output logic        IfErr,
    input  logic        DmReq,
    input  logic        DmRead,
    input  logic [1:0]  DmType,
    input  logic [31:0] DmAddr,
    input  logic [63:0] DmWData,
    output logic        DmAck,
    output logic [63:0] DmRData,
    output logic        DmErr,
    output logic        Busy,
    output logic        MemEnable,
    output logic        MemReadWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemDataIn,
    output logic [1:0]  MemDataType,
    input  logic [31:0] MemDataOut,
    input  logic        MemMOC
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_owner_dm;
    logic             r_last_dm;
    logic             r_rw;
    logic             r_beat;
    logic             r_err;
    logic [1:0]       r_type;
    logic [31:0]      r_addr;
    logic [63:0]      r_wdata;
    logic [63:0]      r_rdata;
    logic [CNT_W-1:0] r_cnt;

    logic w_req_any;
    logic w_grant_dm;
    logic w_dw;
    logic w_moc;
    logic w_tmo;
    logic w_more;

    assign w_req_any  = IfReq | DmReq;
    assign w_grant_dm = DmReq & (~IfReq | ~r_last_dm);
    assign w_dw       = r_owner_dm & (r_type == 2'b11);
    // MOC is not trusted in the first ACCESS cycle (counter still zero)
    assign w_moc      = (r_cnt != '0) & MemMOC;
    assign w_tmo      = (r_cnt == LP_CNT_MAX);
    assign w_more     = w_dw & ~r_beat;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_req_any) w_next = S_ACCESS;
            S_ACCESS: begin
                if (w_moc)      w_next = S_RELEASE;
                else if (w_tmo) w_next = S_DONE;
            end
            S_RELEASE: w_next = w_more ? S_ACCESS : S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_owner_dm <= 1'b0;
            r_last_dm  <= 1'b0;
            r_rw       <= 1'b0;
            r_beat     <= 1'b0;
            r_err      <= 1'b0;
            r_type     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_owner_dm <= w_grant_dm;
                        r_last_dm  <= w_grant_dm;
                        r_addr     <= w_grant_dm ? DmAddr : IfAddr;
                        r_type     <= w_grant_dm ? DmType : 2'b10;
                        r_rw       <= w_grant_dm ? DmRead : 1'b1;
                        r_wdata    <= w_grant_dm ? DmWData : '0;
                        r_beat     <= 1'b0;
                        r_cnt      <= '0;
                        r_err      <= 1'b0;
                        r_rdata    <= '0;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_moc) begin
                        if (r_rw && w_more) r_rdata[63:32] <= MemDataOut;
                        else if (r_rw)      r_rdata[31:0]  <= MemDataOut;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (w_more) begin
                        r_beat <= 1'b1;
                        r_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy         = (r_state != S_IDLE);
    assign MemEnable    = (r_state == S_ACCESS);
    assign MemReadWrite = r_rw;
    assign MemAddress   = r_addr + {29'd0, r_beat, 2'b00};
    assign MemDataType  = w_dw ? 2'b10 : r_type;
    assign MemDataIn    = (w_dw & ~r_beat) ? r_wdata[63:32] : r_wdata[31:0];

    assign IfAck   = (r_state == S_DONE) & ~r_owner_dm;
    assign IfRData = IfAck ? r_rdata[31:0] : '0;
    assign IfErr   = IfAck & r_err;
    assign DmAck   = (r_state == S_DONE) & r_owner_dm;
    assign DmRData = DmAck ? r_rdata : '0;
    assign DmErr   = DmAck & r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte RAM model, ack scoreboard, beat monitor.
// Runs with TIMEOUT=8 so the MOC timeout case stays short.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IfReq;
    logic [31:0] IfAddr;
    logic        IfAck;
    logic [31:0] IfRData;
    logic        IfErr;
    logic        DmReq;
    logic        DmRead;
    logic [1:0]  DmType;
    logic [31:0] DmAddr;
    logic [63:0] DmWData;
    logic        DmAck;
    logic [63:0] DmRData;
    logic        DmErr;
    logic        Busy;
    logic        MemEnable;
    logic        MemReadWrite;
    logic [31:0] MemAddress;
    logic [31:0] MemDataIn;
    logic [1:0]  MemDataType;
    logic [31:0] MemDataOut;
    logic        MemMOC;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(8), .CNT_W(7)) dut (
        .Clk(clk), .Reset_n(rst_n),
        .IfReq(IfReq), .IfAddr(IfAddr), .IfAck(IfAck),
        .IfRData(IfRData), .IfErr(IfErr),
        .DmReq(DmReq), .DmRead(DmRead), .DmType(DmType),
        .DmAddr(DmAddr), .DmWData(DmWData), .DmAck(DmAck),
        .DmRData(DmRData), .DmErr(DmErr), .Busy(Busy),
        .MemEnable(MemEnable), .MemReadWrite(MemReadWrite),
        .MemAddress(MemAddress), .MemDataIn(MemDataIn),
        .MemDataType(MemDataType), .MemDataOut(MemDataOut),
        .MemMOC(MemMOC)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  ty;
        logic        rw;
        logic [31:0] din;
    } beat_t;

    logic [7:0]  mem [0:1023];
    bit          moc_on = 1'b1;
    int          n_chk = 0;
    int          n_err = 0;
    int          n_if_ack = 0;
    logic [32:0] if_exp [$];
    logic [64:0] dm_exp [$];
    bit          ack_order [$];
    beat_t       beat_q [$];
    int          gap_q [$];
    int          hi_q [$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ram_rd(input logic [31:0] a,
                                           input logic [1:0] t);
        logic [9:0] i;
        i = a[9:0];
        case (t)
            2'b00:   return {24'h0, mem[i]};
            2'b01:   return {16'h0, mem[i], mem[i+10'd1]};
            default: return {mem[i], mem[i+10'd1], mem[i+10'd2], mem[i+10'd3]};
        endcase
    endfunction

    task automatic ram_wr(input logic [31:0] a, input logic [1:0] t,
                          input logic [31:0] d);
        logic [9:0] i;
        i = a[9:0];
        case (t)
            2'b00: mem[i] = d[7:0];
            2'b01: begin
                mem[i] = d[15:8]; mem[i+10'd1] = d[7:0];
            end
            default: begin
                mem[i] = d[31:24]; mem[i+10'd1] = d[23:16];
                mem[i+10'd2] = d[15:8]; mem[i+10'd3] = d[7:0];
            end
        endcase
    endtask

    // RAM model: MOC one cycle after Enable, dropped when Enable falls
    initial begin
        MemMOC = 1'b0;
        MemDataOut = '0;
        forever begin
            @(posedge clk);
            if (!rst_n || !MemEnable || !moc_on) begin
                MemMOC <= 1'b0;
            end else begin
                MemMOC <= 1'b1;
                MemDataOut <= ram_rd(MemAddress, MemDataType);
                if (!MemReadWrite) ram_wr(MemAddress, MemDataType, MemDataIn);
            end
        end
    end

    initial begin
        logic [32:0] e_if;
        logic [64:0] e_dm;
        forever begin
            @(negedge clk);
            if (IfAck && DmAck) check("ack_both", 64'(1), 64'(0));
            if (IfAck) begin
                n_if_ack++;
                ack_order.push_back(1'b1);
                if (if_exp.size() == 0) begin
                    check("if_unexp", 64'(1), 64'(0));
                end else begin
                    e_if = if_exp.pop_front();
                    check("if_rdata", 64'(IfRData), 64'(e_if[31:0]));
                    check("if_err", 64'(IfErr), 64'(e_if[32]));
                end
            end
            if (DmAck) begin
                ack_order.push_back(1'b0);
                if (dm_exp.size() == 0) begin
                    check("dm_unexp", 64'(1), 64'(0));
                end else begin
                    e_dm = dm_exp.pop_front();
                    check("dm_rdata", DmRData, e_dm[63:0]);
                    check("dm_err", 64'(DmErr), 64'(e_dm[64]));
                end
            end
        end
    end

    initial begin
        bit prev_en;
        int lo_cnt;
        int hi_cnt;
        prev_en = 1'b0;
        lo_cnt = 0;
        hi_cnt = 0;
        forever begin
            @(negedge clk);
            if (MemEnable && !prev_en) begin
                beat_q.push_back('{MemAddress, MemDataType, MemReadWrite, MemDataIn});
                gap_q.push_back(lo_cnt);
            end
            if (MemEnable) begin
                hi_cnt++;
                lo_cnt = 0;
            end else begin
                if (prev_en) hi_q.push_back(hi_cnt);
                hi_cnt = 0;
                lo_cnt++;
            end
            prev_en = MemEnable;
        end
    end

    task automatic if_req(input logic [31:0] a, input logic [31:0] exp,
                          input logic experr, input int exp_lat);
        int n;
        bit got;
        @(negedge clk);
        IfReq = 1'b1;
        IfAddr = a;
        if_exp.push_back({experr, exp});
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (IfAck) got = 1'b1;
        end
        if (!got) check("if_wait", 64'(0), 64'(1));
        if (exp_lat > 0) check("if_lat", 64'(n), 64'(exp_lat));
        IfReq = 1'b0;
    endtask

    task automatic dm_req(input logic rd, input logic [1:0] ty,
                          input logic [31:0] a, input logic [63:0] wd,
                          input logic [63:0] exp, input logic experr,
                          input int exp_lat, input bit hold);
        int n;
        bit got;
        @(negedge clk);
        DmReq = 1'b1;
        DmRead = rd;
        DmType = ty;
        DmAddr = a;
        DmWData = wd;
        dm_exp.push_back({experr, exp});
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (DmAck) got = 1'b1;
        end
        if (!got) check("dm_wait", 64'(0), 64'(1));
        if (exp_lat > 0) check("dm_lat", 64'(n), 64'(exp_lat));
        if (!hold) DmReq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        IfReq = 1'b0;
        IfAddr = '0;
        DmReq = 1'b0;
        DmRead = 1'b0;
        DmType = 2'b00;
        DmAddr = '0;
        DmWData = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
        mem[256] = 8'hE3; mem[257] = 8'hA0; mem[258] = 8'h10; mem[259] = 8'h05;
        for (int i = 0; i < 8; i++) mem[64+i] = 8'((i + 1) * 17);

        #1;
        check("rst_en", 64'(MemEnable), 64'(0));
        check("rst_busy", 64'(Busy), 64'(0));
        check("rst_ifack", 64'(IfAck), 64'(0));
        check("rst_dmack", 64'(DmAck), 64'(0));
        check("rst_addr", 64'(MemAddress), 64'(0));
        check("rst_type", 64'(MemDataType), 64'(0));
        check("rst_rw", 64'(MemReadWrite), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        beat_q.delete();
        if_req(32'h100, 32'hE3A01005, 1'b0, 4);
        @(negedge clk);
        check("t1_nbeat", 64'(beat_q.size()), 64'(1));
        if (beat_q.size() > 0) begin
            check("t1_addr", 64'(beat_q[0].addr), 64'h100);
            check("t1_type", 64'(beat_q[0].ty), 64'h2);
            check("t1_rw", 64'(beat_q[0].rw), 64'h1);
        end

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        beat_q.delete();
        ack_order.delete();
        fork
            begin
                dm_req(1'b0, 2'b00, 32'h20, 64'hAB, 64'h0, 1'b0, 0, 1'b1);
                dm_req(1'b1, 2'b00, 32'h20, 64'h0, 64'hAB, 1'b0, 0, 1'b0);
            end
            if_req(32'h0, 32'hAABBCCDD, 1'b0, 0);
        join
        @(negedge clk);
        check("t2_nack", 64'(ack_order.size()), 64'(3));
        if (ack_order.size() == 3) begin
            check("t2_ord0", 64'(ack_order[0]), 64'(0));
            check("t2_ord1", 64'(ack_order[1]), 64'(1));
            check("t2_ord2", 64'(ack_order[2]), 64'(0));
        end
        if (beat_q.size() > 0) begin
            check("t2_addr", 64'(beat_q[0].addr), 64'h20);
            check("t2_type", 64'(beat_q[0].ty), 64'h0);
            check("t2_rw", 64'(beat_q[0].rw), 64'h0);
            check("t2_din", 64'(beat_q[0].din), 64'hAB);
        end

        beat_q.delete();
        gap_q.delete();
        dm_req(1'b1, 2'b11, 32'h40, 64'h0, 64'h1122334455667788, 1'b0, 7, 1'b0);
        @(negedge clk);
        check("t3_nbeat", 64'(beat_q.size()), 64'(2));
        if (beat_q.size() == 2 && gap_q.size() == 2) begin
            check("t3_a0", 64'(beat_q[0].addr), 64'h40);
            check("t3_a1", 64'(beat_q[1].addr), 64'h44);
            check("t3_ty1", 64'(beat_q[1].ty), 64'h2);
            check("t3_gap", 64'(gap_q[1]), 64'(1));
        end

        beat_q.delete();
        dm_req(1'b0, 2'b11, 32'h80, 64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0, 7, 1'b0);
        @(negedge clk);
        check("t4_nbeat", 64'(beat_q.size()), 64'(2));
        if (beat_q.size() == 2) begin
            check("t4_d0", 64'(beat_q[0].din), 64'hDEADBEEF);
            check("t4_a1", 64'(beat_q[1].addr), 64'h84);
            check("t4_d1", 64'(beat_q[1].din), 64'hCAFEF00D);
        end
        dm_req(1'b1, 2'b10, 32'h84, 64'h0, 64'hCAFEF00D, 1'b0, 4, 1'b0);
        dm_req(1'b1, 2'b10, 32'h80, 64'h0, 64'hDEADBEEF, 1'b0, 4, 1'b0);

        moc_on = 1'b0;
        hi_q.delete();
        dm_req(1'b1, 2'b10, 32'h40, 64'h0, 64'h0, 1'b1, 9, 1'b0);
        @(negedge clk);
        check("t5_nhi", 64'(hi_q.size()), 64'(1));
        if (hi_q.size() > 0) check("t5_hi", 64'(hi_q[0]), 64'(8));
        moc_on = 1'b1;
        dm_req(1'b1, 2'b10, 32'h44, 64'h0, 64'h55667788, 1'b0, 4, 1'b0);
        dm_req(1'b1, 2'b01, 32'h42, 64'h0, 64'h3344, 1'b0, 4, 1'b0);

        n_if_ack = 0;
        fork
            if_req(32'h100, 32'hE3A01005, 1'b0, 0);
            begin
                repeat (3) @(negedge clk);
                check("t6_en_pre", 64'(MemEnable), 64'(1));
                rst_n = 1'b0;
                #1;
                check("t6_en", 64'(MemEnable), 64'(0));
                check("t6_busy", 64'(Busy), 64'(0));
                check("t6_ack", 64'(IfAck), 64'(0));
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        @(negedge clk);
        check("t6_nack", 64'(n_if_ack), 64'(1));
        check("t6_left", 64'(if_exp.size() + dm_exp.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
